float_mul_arbiter: RTL and testbench

FLOAT_MUL_ARBITER -- requirements
Module: float_mul_arbiter

---
 rtl/float_mul_arbiter_pkg.sv | 35 +++
 rtl/float_rr_pick.sv | 24 ++
 rtl/float_mul_arbiter.sv | 136 +++++++++++++
 tb/tb_float_mul_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_mul_arbiter_pkg.sv
// Shared definitions for the two-requester float multiply arbiter:
// controller state encoding, status flag bit positions and the default
// core-abort timeout.
package float_mul_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        RESP  = 3'd4
    } arbState_t;

    // Bit positions inside the 4-bit Flags word.
    localparam int FLAG_OVER    = 3;
    localparam int FLAG_UNDER   = 2;
    localparam int FLAG_ZERO    = 1;
    localparam int FLAG_TIMEOUT = 0;

    // Core cycles to wait for done before the job is aborted.
    localparam int TIMEOUT_DEFAULT = 15;

    // Assemble a Flags word from individual status bits.
    function automatic logic [3:0] packFlags(input logic over, input logic under,
                                             input logic zero, input logic timeout);
        logic [3:0] f;
        f               = '0;
        f[FLAG_OVER]    = over;
        f[FLAG_UNDER]   = under;
        f[FLAG_ZERO]    = zero;
        f[FLAG_TIMEOUT] = timeout;
        return f;
    endfunction

endpackage

// File: rtl/float_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright; on a tie the
// requester that was not served last wins.
module float_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Combinational winner selection.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant_valid = |req;
        grant_idx   = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last;
            default: grant_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/float_mul_arbiter.sv
// Arbitrates two requesters onto one shared multi-cycle float multiplier
// core. Operands are latched at grant, the core is run until done or
// timeout, held one extra drain cycle so it returns to its initial step,
// and the result is reported with a one-cycle done pulse to the owner.
module float_mul_arbiter
    import float_mul_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        Req0_Sig,
    input  logic        Req1_Sig,
    input  logic [31:0] A0,
    input  logic [31:0] B0,
    input  logic [31:0] A1,
    input  logic [31:0] B1,
    output logic        Done0_Sig,
    output logic        Done1_Sig,
    output logic [31:0] Result,
    output logic [3:0]  Flags,
    output logic        Owner,
    output logic [31:0] Mul_A,
    output logic [31:0] Mul_B,
    output logic        Mul_Start_Sig,
    input  logic [31:0] Mul_Result,
    input  logic [3:0]  Mul_Done_Sig
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arbState_t        state;
    arbState_t        nextState;
    logic             pickValid;
    logic             pickIdx;
    logic             winner;
    logic             lastServed;
    logic [CNT_W-1:0] toCount;
    logic [31:0]      capResult;
    logic [2:0]       capStatus;
    logic             coreDone;
    logic             expired;

    assign coreDone = Mul_Done_Sig[0];
    assign expired  = (toCount == CNT_W'(TIMEOUT - 1));

    float_rr_pick uPick (
        .req         ({Req1_Sig, Req0_Sig}),
        .last        (lastServed),
        .grant_valid (pickValid),
        .grant_idx   (pickIdx)
    );

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        // NOTE: state is updated with non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (!RSTn) state <= IDLE;
        else       state <= nextState;
    end

    // Next-state decode and core run enable.
    always_comb begin
        nextState     = state;
        Mul_Start_Sig = 1'b0;
        case (state)
            IDLE:  if (pickValid) nextState = GRANT;
            GRANT: nextState = RUN;
            RUN: begin
                Mul_Start_Sig = 1'b1;
                if (coreDone)     nextState = DRAIN;
                else if (expired) nextState = RESP;
            end
            DRAIN: begin
                Mul_Start_Sig = 1'b1;
                nextState     = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Job datapath: winner, operand latch, timeout count, capture and report.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            winner     <= 1'b0;
            lastServed <= 1'b1;
            toCount    <= '0;
            Mul_A      <= '0;
            Mul_B      <= '0;
            capResult  <= '0;
            capStatus  <= '0;
            Result     <= '0;
            Flags      <= '0;
            Owner      <= 1'b0;
            Done0_Sig  <= 1'b0;
            Done1_Sig  <= 1'b0;
        end else begin
            Done0_Sig <= 1'b0;
            Done1_Sig <= 1'b0;
            case (state)
                IDLE: if (pickValid) winner <= pickIdx;
                GRANT: begin
                    Mul_A   <= winner ? A1 : A0;
                    Mul_B   <= winner ? B1 : B0;
                    toCount <= '0;
                end
                RUN: begin
                    toCount <= toCount + CNT_W'(1);
                    if (coreDone) begin
                        capResult <= Mul_Result;
                        capStatus <= Mul_Done_Sig[3:1];
                    end
                end
                default: ;
            endcase

            // Report registers load on entry to RESP so they are visible
            // in the same cycle as the done pulse.
            if (nextState == RESP) begin
                if (state == DRAIN) begin
                    Result <= capResult;
                    Flags  <= packFlags(capStatus[2], capStatus[1], capStatus[0], 1'b0);
                end else begin
                    Result <= '0;
                    Flags  <= packFlags(1'b0, 1'b0, 1'b0, 1'b1);
                end
                Owner      <= winner;
                lastServed <= winner;
                Done0_Sig  <= ~winner;
                Done1_Sig  <= winner;
            end
        end
    end

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Scoreboard bench for float_mul_arbiter. A behavioural core stub returns
// hand-computed products seven start cycles after the run begins; the
// stimulus pushes expected responses and a monitor checks each done pulse.
module tb_float_mul_arbiter;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        Req0_Sig, Req1_Sig;
    logic [31:0] A0, B0, A1, B1;
    logic        Done0_Sig, Done1_Sig;
    logic [31:0] Result;
    logic [3:0]  Flags;
    logic        Owner;
    logic [31:0] Mul_A, Mul_B;
    logic        Mul_Start_Sig;
    logic [31:0] Mul_Result;
    logic [3:0]  Mul_Done_Sig;

    always #5 CLK = ~CLK;

    float_mul_arbiter #(.TIMEOUT(15)) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .Req0_Sig      (Req0_Sig),
        .Req1_Sig      (Req1_Sig),
        .A0            (A0),
        .B0            (B0),
        .A1            (A1),
        .B1            (B1),
        .Done0_Sig     (Done0_Sig),
        .Done1_Sig     (Done1_Sig),
        .Result        (Result),
        .Flags         (Flags),
        .Owner         (Owner),
        .Mul_A         (Mul_A),
        .Mul_B         (Mul_B),
        .Mul_Start_Sig (Mul_Start_Sig),
        .Mul_Result    (Mul_Result),
        .Mul_Done_Sig  (Mul_Done_Sig)
    );

    // ---------------- core stub ----------------
    logic [2:0]  stubStep = '0;
    logic        stubHang;
    logic        stubDone;
    logic [34:0] stubWord;

    // Hand-computed products as {over, under, zero, result}.
    function automatic logic [34:0] coreTable(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return {3'b000, 32'h40C00000}; // 2*3 = 6
            {32'h3FC00000, 32'h40000000}: return {3'b000, 32'h40400000}; // 1.5*2 = 3
            {32'h40800000, 32'h3F000000}: return {3'b000, 32'h40000000}; // 4*0.5 = 2
            {32'hC0000000, 32'h40400000}: return {3'b000, 32'hC0C00000}; // -2*3 = -6
            {32'h00000000, 32'h40A00000}: return {3'b001, 32'h00000000}; // 0*5 = 0
            {32'h7F000000, 32'h7F000000}: return {3'b100, 32'h7F800000}; // overflow
            default:                      return {3'b000, 32'hDEADBEEF};
        endcase
    endfunction

    always_ff @(posedge CLK) begin
        if (!Mul_Start_Sig || stubHang) stubStep <= '0;
        else                            stubStep <= stubStep + 3'd1;
    end

    assign stubDone     = Mul_Start_Sig && !stubHang && (stubStep == 3'd6);
    assign stubWord     = coreTable(Mul_A, Mul_B);
    assign Mul_Result   = stubWord[31:0];
    assign Mul_Done_Sig = {stubWord[34:32], stubDone};

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        owner;
        logic [31:0] result;
        logic [3:0]  flags;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic o, input logic [31:0] r, input logic [3:0] f);
        exp_t e;
        e.owner  = o;
        e.result = r;
        e.flags  = f;
        expQ.push_back(e);
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge CLK) begin
        exp_t e;
        if (RSTn === 1'b1 && (Done0_Sig === 1'b1 || Done1_Sig === 1'b1)) begin
            check("done_exclusive", {31'b0, Done0_Sig & Done1_Sig}, 32'd0);
            check("start_low_at_done", {31'b0, Mul_Start_Sig}, 32'd0);
            check("job_expected", {31'b0, expQ.size() != 0}, 32'd1);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                check("done_index", {31'b0, Done1_Sig}, {31'b0, e.owner});
                check("owner", {31'b0, Owner}, {31'b0, e.owner});
                check("result", Result, e.result);
                check("flags", {28'b0, Flags}, {28'b0, e.flags});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic doReset();
        @(negedge CLK);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // Raise the given requests and wait for nJobs done pulses. Without
    // holdBoth each request drops on its own done pulse.
    task automatic runJobs(input logic r0, input logic r1, input int nJobs,
                           input logic holdBoth, input string tag);
        int seen = 0;
        int cyc  = 0;
        Req0_Sig = r0;
        Req1_Sig = r1;
        while (seen < nJobs && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (Done0_Sig || Done1_Sig) begin
                seen++;
                if (!holdBoth) begin
                    if (Done0_Sig) Req0_Sig = 1'b0;
                    if (Done1_Sig) Req1_Sig = 1'b0;
                end
            end
        end
        Req0_Sig = 1'b0;
        Req1_Sig = 1'b0;
        check({tag, "_jobs_done"}, seen, nJobs);
    endtask

    // Wait (bounded) for the core run enable to rise.
    task automatic waitStart(input string tag, output logic seen);
        int cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge CLK);
            cyc++;
            if (Mul_Start_Sig) seen = 1'b1;
        end
        check({tag, "_start_seen"}, {31'b0, seen}, 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        int   n;
        RSTn = 1'b0; Req0_Sig = 1'b0; Req1_Sig = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        stubHang = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);

        // Reset state.
        check("rst_result", Result, 32'd0);
        check("rst_flags", {28'b0, Flags}, 32'd0);
        check("rst_owner", {31'b0, Owner}, 32'd0);
        check("rst_mul_a", Mul_A, 32'd0);
        check("rst_mul_b", Mul_B, 32'd0);
        check("rst_start", {31'b0, Mul_Start_Sig}, 32'd0);
        check("rst_done", {30'b0, Done1_Sig, Done0_Sig}, 32'd0);

        // Single request: 2.0 * 3.0.
        A0 = 32'h40000000; B0 = 32'h40400000;
        pushExp(1'b0, 32'h40C00000, 4'b0000);
        runJobs(1'b1, 1'b0, 1, 1'b0, "single");

        // Simultaneous requests right after reset: requester 0 first.
        doReset();
        A0 = 32'h3FC00000; B0 = 32'h40000000;
        A1 = 32'h40800000; B1 = 32'h3F000000;
        pushExp(1'b0, 32'h40400000, 4'b0000);
        pushExp(1'b1, 32'h40000000, 4'b0000);
        runJobs(1'b1, 1'b1, 2, 1'b0, "tie");

        // Both held continuously: grants alternate 0, 1, 0, 1.
        A0 = 32'h40000000; B0 = 32'h40400000;
        A1 = 32'hC0000000; B1 = 32'h40400000;
        pushExp(1'b0, 32'h40C00000, 4'b0000);
        pushExp(1'b1, 32'hC0C00000, 4'b0000);
        pushExp(1'b0, 32'h40C00000, 4'b0000);
        pushExp(1'b1, 32'hC0C00000, 4'b0000);
        runJobs(1'b1, 1'b1, 4, 1'b1, "alt");

        // Core never answers: abort after 15 RUN cycles.
        @(negedge CLK);
        stubHang = 1'b1;
        A1 = 32'h40000000; B1 = 32'h40400000;
        pushExp(1'b1, 32'h00000000, 4'b0001);
        Req1_Sig = 1'b1;
        waitStart("timeout", seen);
        n = 0;
        while (!(Done0_Sig || Done1_Sig) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        Req1_Sig = 1'b0;
        check("timeout_latency", n, 32'd15);
        check("timeout_start_low", {31'b0, Mul_Start_Sig}, 32'd0);
        @(negedge CLK);
        stubHang = 1'b0;

        // Operand change during RUN must not reach the core.
        A0 = 32'hC0000000; B0 = 32'h40400000;
        pushExp(1'b0, 32'hC0C00000, 4'b0000);
        Req0_Sig = 1'b1;
        waitStart("opchange", seen);
        A0 = 32'h40A00000; B0 = 32'h3F800000;
        @(negedge CLK);
        check("run_mul_a_stable", Mul_A, 32'hC0000000);
        check("run_mul_b_stable", Mul_B, 32'hC0400000 ^ 32'h80000000);
        repeat (3) @(negedge CLK);
        check("run_mul_a_stable_late", Mul_A, 32'hC0000000);
        runJobs(1'b1, 1'b0, 1, 1'b0, "opchange");

        // Reset during RUN: everything clears at once, no done pulse.
        A0 = 32'h3FC00000; B0 = 32'h40000000;
        Req0_Sig = 1'b1;
        waitStart("midreset", seen);
        repeat (2) @(negedge CLK);
        #2 RSTn = 1'b0;
        #1;
        check("mid_rst_result", Result, 32'd0);
        check("mid_rst_flags", {28'b0, Flags}, 32'd0);
        check("mid_rst_owner", {31'b0, Owner}, 32'd0);
        check("mid_rst_mul_a", Mul_A, 32'd0);
        check("mid_rst_mul_b", Mul_B, 32'd0);
        check("mid_rst_start", {31'b0, Mul_Start_Sig}, 32'd0);
        check("mid_rst_done", {30'b0, Done1_Sig, Done0_Sig}, 32'd0);
        @(negedge CLK);
        Req0_Sig = 1'b0;
        RSTn = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge CLK);
            if (Done0_Sig || Done1_Sig) n++;
        end
        check("no_done_after_abort", n, 32'd0);

        // Normal service after the abort: zero and overflow status.
        A0 = 32'h00000000; B0 = 32'h40A00000;
        pushExp(1'b0, 32'h00000000, 4'b0010);
        runJobs(1'b1, 1'b0, 1, 1'b0, "post_reset_zero");
        A1 = 32'h7F000000; B1 = 32'h7F000000;
        pushExp(1'b1, 32'h7F800000, 4'b1000);
        runJobs(1'b0, 1'b1, 1, 1'b0, "overflow");

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
